// File: rtl/clock_timekeeper.sv
// clock_timekeeper: time-of-day counter for the digital clock.
//   Divides clk by TICK_DIV into a one-second tick and keeps HH:MM:SS, with a
//   12/24-hour display mode, a set mode with per-field adjustment, and one
//   alarm with a sticky flag.
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   set_clk                       1 = set mode: time frozen, set_* inputs live
//   set_hour/set_min/set_sec      rising edge in set mode adjusts one field
//   mode_12h                      1 = 12-hour display (display only)
//   alarm_en/alarm_hour/alarm_min alarm compare enable and target (binary)
//   alarm_ack                     clears alarm_flag
//   sec_*/min_*/hour_*            BCD display digits
//   pm                            internal hour >= 12
//   sec_p/min_p/hour_p/day_p      registered one-cycle carry pulses
//   alarm_flag                    sticky alarm indication
`timescale 1ns/1ps
module clock_timekeeper #(
    parameter int unsigned TICK_DIV  = 10,
    parameter int unsigned PRE_W     = 4,
    parameter int unsigned INIT_HOUR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_clk,
    input  logic       set_hour,
    input  logic       set_min,
    input  logic       set_sec,
    input  logic       mode_12h,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_ack,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hour_lo,
    output logic [3:0] hour_hi,
    output logic       pm,
    output logic       sec_p,
    output logic       min_p,
    output logic       hour_p,
    output logic       day_p,
    output logic       alarm_flag
);

    localparam logic [PRE_W-1:0] PreMax   = PRE_W'(TICK_DIV - 1);
    localparam logic [4:0]       HourInit = 5'(INIT_HOUR);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0] sec_lo_q, sec_lo_d, sec_hi_q, sec_hi_d;
    logic [3:0] min_lo_q, min_lo_d, min_hi_q, min_hi_d;
    logic [4:0] hour_q, hour_d;
    logic       sec_p_q, min_p_q, hour_p_q, day_p_q;
    logic       alarm_flag_q, alarm_flag_d;
    logic       set_hour_q, set_min_q, set_sec_q;

    logic       tick, sec_carry, min_carry, day_carry, alarm_hit;
    logic       rise_hour, rise_min, rise_sec;
    logic [5:0] min_bin_d;
    logic [4:0] disp_hour;

    always_comb begin
        tick      = !set_clk && (pre_q == PreMax);
        sec_carry = tick && (sec_hi_q == 4'd5) && (sec_lo_q == 4'd9);
        min_carry = sec_carry && (min_hi_q == 4'd5) && (min_lo_q == 4'd9);
        day_carry = min_carry && (hour_q == 5'd23);

        // Edges only act in set mode; history is sampled in both modes.
        rise_hour = set_clk && set_hour && !set_hour_q;
        rise_min  = set_clk && set_min && !set_min_q;
        rise_sec  = set_clk && set_sec && !set_sec_q;

        pre_d    = (set_clk || tick) ? '0 : pre_q + 1'b1;
        sec_lo_d = sec_lo_q;
        sec_hi_d = sec_hi_q;
        min_lo_d = min_lo_q;
        min_hi_d = min_hi_q;
        hour_d   = hour_q;

        if (tick) begin
            sec_lo_d = (sec_lo_q == 4'd9) ? 4'd0 : sec_lo_q + 4'd1;
            if (sec_lo_q == 4'd9) begin
                sec_hi_d = (sec_hi_q == 4'd5) ? 4'd0 : sec_hi_q + 4'd1;
            end
        end
        if (sec_carry) begin
            min_lo_d = (min_lo_q == 4'd9) ? 4'd0 : min_lo_q + 4'd1;
            if (min_lo_q == 4'd9) begin
                min_hi_d = (min_hi_q == 4'd5) ? 4'd0 : min_hi_q + 4'd1;
            end
        end
        if (min_carry) begin
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end

        // Set-mode adjustments never carry between fields.
        if (rise_hour) begin
            hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
        if (rise_min) begin
            min_lo_d = (min_lo_q == 4'd9) ? 4'd0 : min_lo_q + 4'd1;
            if (min_lo_q == 4'd9) begin
                min_hi_d = (min_hi_q == 4'd5) ? 4'd0 : min_hi_q + 4'd1;
            end
        end
        if (rise_sec) begin
            sec_lo_d = 4'd0;
            sec_hi_d = 4'd0;
        end

        // Alarm fires only when a run tick lands on HH:MM:00.
        min_bin_d = {2'b00, min_hi_d} * 6'd10 + {2'b00, min_lo_d};
        alarm_hit = sec_carry && alarm_en && (hour_d == alarm_hour) && (min_bin_d == alarm_min);
        if (alarm_hit) begin
            alarm_flag_d = 1'b1;
        end else if (alarm_ack) begin
            alarm_flag_d = 1'b0;
        end else begin
            alarm_flag_d = alarm_flag_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q        <= '0;
            sec_lo_q     <= 4'd0;
            sec_hi_q     <= 4'd0;
            min_lo_q     <= 4'd0;
            min_hi_q     <= 4'd0;
            hour_q       <= HourInit;
            sec_p_q      <= 1'b0;
            min_p_q      <= 1'b0;
            hour_p_q     <= 1'b0;
            day_p_q      <= 1'b0;
            alarm_flag_q <= 1'b0;
            set_hour_q   <= 1'b0;
            set_min_q    <= 1'b0;
            set_sec_q    <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            sec_lo_q     <= sec_lo_d;
            sec_hi_q     <= sec_hi_d;
            min_lo_q     <= min_lo_d;
            min_hi_q     <= min_hi_d;
            hour_q       <= hour_d;
            sec_p_q      <= tick;
            min_p_q      <= sec_carry;
            hour_p_q     <= min_carry;
            day_p_q      <= day_carry;
            alarm_flag_q <= alarm_flag_d;
            set_hour_q   <= set_hour;
            set_min_q    <= set_min;
            set_sec_q    <= set_sec;
        end
    end

    // Display hour: 12-hour mode maps 0 -> 12 and 13..23 -> 1..11.
    always_comb begin
        if (mode_12h && (hour_q == 5'd0)) begin
            disp_hour = 5'd12;
        end else if (mode_12h && (hour_q > 5'd12)) begin
            disp_hour = hour_q - 5'd12;
        end else begin
            disp_hour = hour_q;
        end
        if (disp_hour >= 5'd20) begin
            hour_hi = 4'd2;
            hour_lo = 4'(disp_hour - 5'd20);
        end else if (disp_hour >= 5'd10) begin
            hour_hi = 4'd1;
            hour_lo = 4'(disp_hour - 5'd10);
        end else begin
            hour_hi = 4'd0;
            hour_lo = disp_hour[3:0];
        end
    end

    assign sec_lo     = sec_lo_q;
    assign sec_hi     = sec_hi_q;
    assign min_lo     = min_lo_q;
    assign min_hi     = min_hi_q;
    assign pm         = (hour_q >= 5'd12);
    assign sec_p      = sec_p_q;
    assign min_p      = min_p_q;
    assign hour_p     = hour_p_q;
    assign day_p      = day_p_q;
    assign alarm_flag = alarm_flag_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
`timescale 1ns/1ps
module tb_clock_timekeeper;

    localparam int TickDiv  = 4;
    localparam int InitHour = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_clk = 1'b0, set_hour = 1'b0, set_min = 1'b0, set_sec = 1'b0;
    logic       mode_12h = 1'b0, alarm_en = 1'b0, alarm_ack = 1'b0;
    logic [4:0] alarm_hour = 5'd0;
    logic [5:0] alarm_min = 6'd0;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi;
    logic       pm, sec_p, min_p, hour_p, day_p, alarm_flag;

    clock_timekeeper #(
        .TICK_DIV (TickDiv),
        .PRE_W    (3),
        .INIT_HOUR(InitHour)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set_clk   (set_clk),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .mode_12h  (mode_12h),
        .alarm_en  (alarm_en),
        .alarm_hour(alarm_hour),
        .alarm_min (alarm_min),
        .alarm_ack (alarm_ack),
        .sec_lo    (sec_lo),
        .sec_hi    (sec_hi),
        .min_lo    (min_lo),
        .min_hi    (min_hi),
        .hour_lo   (hour_lo),
        .hour_hi   (hour_hi),
        .pm        (pm),
        .sec_p     (sec_p),
        .min_p     (min_p),
        .hour_p    (hour_p),
        .day_p     (day_p),
        .alarm_flag(alarm_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time of day as seconds since midnight.
    int tod;
    int run_cnt;
    bit m_flag, e_sec_p, e_min_p, e_hour_p, e_day_p;
    bit prev_h, prev_m, prev_s;
    int cnt_sec_p, cnt_min_p;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tod = InitHour * 3600;
        run_cnt = 0;
        m_flag = 0;
        e_sec_p = 0; e_min_p = 0; e_hour_p = 0; e_day_p = 0;
        prev_h = 0; prev_m = 0; prev_s = 0;
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step();
        int h, m, s, nt, at;
        bit t;
        t = 0;
        nt = tod;
        if (set_clk) begin
            run_cnt = 0;
            h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
            if (set_hour && !prev_h) h = (h + 1) % 24;
            if (set_min && !prev_m) m = (m + 1) % 60;
            if (set_sec && !prev_s) s = 0;
            nt = h * 3600 + m * 60 + s;
        end else begin
            run_cnt++;
            if (run_cnt == TickDiv) begin
                run_cnt = 0;
                t = 1;
                nt = (tod + 1) % 86400;
            end
        end
        e_sec_p  = t;
        e_min_p  = t && (nt % 60 == 0);
        e_hour_p = t && (nt % 3600 == 0);
        e_day_p  = t && (nt == 0);
        at = int'(alarm_hour) * 3600 + int'(alarm_min) * 60;
        if (t && alarm_en && alarm_hour < 24 && alarm_min < 60 && nt == at) m_flag = 1;
        else if (alarm_ack) m_flag = 0;
        tod = nt;
        prev_h = set_hour; prev_m = set_min; prev_s = set_sec;
    endtask

    task automatic check_all(input string ph);
        int h, m, s, dh;
        h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
        dh = h;
        if (mode_12h) dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        check({ph, ".sec_lo"}, 8'(sec_lo), 8'(s % 10));
        check({ph, ".sec_hi"}, 8'(sec_hi), 8'(s / 10));
        check({ph, ".min_lo"}, 8'(min_lo), 8'(m % 10));
        check({ph, ".min_hi"}, 8'(min_hi), 8'(m / 10));
        check({ph, ".hour_lo"}, 8'(hour_lo), 8'(dh % 10));
        check({ph, ".hour_hi"}, 8'(hour_hi), 8'(dh / 10));
        check({ph, ".pm"}, 8'(pm), 8'(h >= 12));
        check({ph, ".sec_p"}, 8'(sec_p), 8'(e_sec_p));
        check({ph, ".min_p"}, 8'(min_p), 8'(e_min_p));
        check({ph, ".hour_p"}, 8'(hour_p), 8'(e_hour_p));
        check({ph, ".day_p"}, 8'(day_p), 8'(e_day_p));
        check({ph, ".alarm_flag"}, 8'(alarm_flag), 8'(m_flag));
    endtask

    task automatic cycle(input string ph);
        model_step();
        @(posedge clk);
        #1;
        if (sec_p === 1'b1) cnt_sec_p++;
        if (min_p === 1'b1) cnt_min_p++;
        check_all(ph);
    endtask

    task automatic press(input int which, input int n, input string ph);
        repeat (n) begin
            case (which)
                0: set_hour = 1'b1;
                1: set_min = 1'b1;
                default: set_sec = 1'b1;
            endcase
            cycle(ph);
            set_hour = 1'b0; set_min = 1'b0; set_sec = 1'b0;
            cycle(ph);
        end
    endtask

    // Enter set mode (if not already) and load HH:MM:00 by edge presses.
    task automatic set_time(input int h, input int m, input string ph);
        set_clk = 1'b1;
        cycle(ph);
        press(0, (h - tod / 3600 + 24) % 24, ph);
        press(1, (m - (tod / 60) % 60 + 60) % 60, ph);
        press(2, 1, ph);
    endtask

    task automatic run(input int n, input string ph);
        set_clk = 1'b0;
        repeat (n) cycle(ph);
    endtask

    task automatic async_reset(input string ph);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(ph);
        check({ph, ".hour_lo_init"}, 8'(hour_lo), 8'(InitHour % 10));
        check({ph, ".sec_lo_zero"}, 8'(sec_lo), 8'd0);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hours[5];
        int dhi[5];
        int dlo[5];
        int dpm[5];
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // 1: one minute of run time.
        cnt_sec_p = 0; cnt_min_p = 0;
        run(TickDiv * 60, "t1");
        check("t1.min_lo_const", 8'(min_lo), 8'd1);
        check("t1.sec_hi_const", 8'(sec_hi), 8'd0);
        check("t1.min_p_now", 8'(min_p), 8'd1);
        check("t1.sec_p_count", 8'(cnt_sec_p), 8'd60);
        check("t1.min_p_count", 8'(cnt_min_p), 8'd1);

        // 2: day rollover from 23:59:58.
        set_time(23, 59, "t2set");
        run(TickDiv * 58, "t2run");
        check("t2.pm_before", 8'(pm), 8'd1);
        run(TickDiv * 2, "t2roll");
        check("t2.hour_hi", 8'(hour_hi), 8'd0);
        check("t2.hour_lo", 8'(hour_lo), 8'd0);
        check("t2.day_p", 8'(day_p), 8'd1);
        check("t2.hour_p", 8'(hour_p), 8'd1);
        check("t2.pm_after", 8'(pm), 8'd0);

        // 3: 12-hour display table.
        hours = '{0, 11, 12, 13, 23};
        dhi   = '{1, 1, 1, 0, 1};
        dlo   = '{2, 1, 2, 1, 1};
        dpm   = '{0, 0, 1, 1, 1};
        mode_12h = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_time(hours[i], 0, "t3");
            check("t3.hour_hi_12h", 8'(hour_hi), 8'(dhi[i]));
            check("t3.hour_lo_12h", 8'(hour_lo), 8'(dlo[i]));
            check("t3.pm_12h", 8'(pm), 8'(dpm[i]));
        end
        mode_12h = 1'b0;

        // 4: set-mode field behaviour, no carries.
        set_time(10, 59, "t4");
        press(1, 1, "t4");
        press(2, 1, "t4");
        check("t4.hour_lo_nocarry", 8'(hour_lo), 8'd0);
        check("t4.hour_hi_nocarry", 8'(hour_hi), 8'd1);
        check("t4.min_hi_wrap", 8'(min_hi), 8'd0);
        press(0, 15, "t4");
        check("t4.hour_lo_wrap", 8'(hour_lo), 8'd1);
        check("t4.hour_hi_wrap", 8'(hour_hi), 8'd0);
        set_min = 1'b1;
        repeat (5) cycle("t4hold");
        set_min = 1'b0;
        cycle("t4hold");
        check("t4.min_lo_hold", 8'(min_lo), 8'd1);

        // 5: alarm at 07:30.
        alarm_hour = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1;
        set_time(7, 29, "t5");
        run(TickDiv * 60 - 1, "t5run");
        check("t5.flag_before", 8'(alarm_flag), 8'd0);
        run(1, "t5hit");
        check("t5.flag_set", 8'(alarm_flag), 8'd1);
        check("t5.min_hi_hit", 8'(min_hi), 8'd3);
        alarm_ack = 1'b1;
        cycle("t5ack");
        alarm_ack = 1'b0;
        check("t5.flag_ack", 8'(alarm_flag), 8'd0);
        alarm_en = 1'b0;
        set_time(7, 29, "t5b");
        run(TickDiv * 61, "t5brun");
        check("t5.flag_disabled", 8'(alarm_flag), 8'd0);

        // 6: asynchronous reset mid-count and in set mode.
        set_time(5, 12, "t6");
        run(TickDiv * 34, "t6run");
        check("t6.sec_hi_34", 8'(sec_hi), 8'd3);
        async_reset("t6rst");
        run(TickDiv * 3, "t6after");
        set_clk = 1'b1;
        press(0, 3, "t6set");
        set_hour = 1'b1;
        cycle("t6set");
        async_reset("t6rstset");
        set_hour = 1'b0;
        cycle("t6set");

        // 7: randomized mix against the model, starting near midnight.
        set_time(23, 58, "t7set");
        set_clk = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            int nm;
            if ($urandom_range(0, 59) == 0) set_clk = ~set_clk;
            set_hour  = ($urandom_range(0, 3) == 0);
            set_min   = ($urandom_range(0, 3) == 0);
            set_sec   = ($urandom_range(0, 7) == 0);
            mode_12h  = 1'($urandom_range(0, 1));
            alarm_en  = ($urandom_range(0, 3) != 0);
            alarm_ack = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) != 0) begin
                nm = (tod / 60 + 1) % 1440;
                alarm_hour = 5'(nm / 60);
                alarm_min  = 6'(nm % 60);
            end else begin
                alarm_hour = 5'($urandom_range(0, 31));
                alarm_min  = 6'($urandom_range(0, 63));
            end
            cycle("t7");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
- Parametrised time-of-day counter for the digital clock: prescales `clk` to a one-second tick and keeps HH:MM:SS.
- Supports a 12/24-hour display mode, a set mode with per-field adjustment, and a single alarm with sticky flag.
- Outputs BCD digits for the display/seven-segment stage, plus carry pulses for downstream logic (chime, date).

Parameters:
TICK_DIV, 10, clk cycles per one-second tick (>=2)
PRE_W, 4, prescaler width; must satisfy 2^PRE_W >= TICK_DIV
INIT_HOUR, 0, hour (0-23, binary) loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
set_clk  in  1  1 = set mode (time frozen, set inputs live)
set_hour  in  1  rising edge in set mode: hour +1, wraps 23->0
set_min  in  1  rising edge in set mode: minute +1, wraps 59->00, no hour carry
set_sec  in  1  rising edge in set mode: seconds cleared to 00
mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display
alarm_en  in  1  alarm compare enable
alarm_hour  in  5  alarm hour, binary 0-23
alarm_min  in  6  alarm minute, binary 0-59
alarm_ack  in  1  clears alarm_flag
sec_lo  out  4  seconds units BCD
sec_hi  out  4  seconds tens BCD (0-5)
min_lo  out  4  minutes units BCD
min_hi  out  4  minutes tens BCD (0-5)
hour_lo  out  4  display hour units BCD
hour_hi  out  4  display hour tens BCD
pm  out  1  1 when internal hour >= 12, in both modes
sec_p  out  1  1-cycle pulse per counted second
min_p  out  1  1-cycle pulse on seconds 59->00
hour_p  out  1  1-cycle pulse on minutes 59->00
day_p  out  1  1-cycle pulse on 23:59:59->00:00:00
alarm_flag  out  1  sticky alarm indication

Behaviour:
- Reset, asynchronous:
  - prescaler = 0; seconds = 00; minutes = 00; hour = INIT_HOUR.
  - All pulses = 0; alarm_flag = 0; set-edge history registers = 0.
- Internal state:
  - Seconds and minutes are held as BCD digit pairs.
  - Hour is held as binary 0-23.
  - Display digits are combinational from registers, so a count is visible the cycle after the tick edge.
- Prescaler (set_clk = 0):
  - Counts 0..TICK_DIV-1; tick = (pre == TICK_DIV-1); wraps to 0 on tick.
- Run tick, all updates in the same clock edge:
  - sec_lo +1, carry at 9 into sec_hi; carry at 5 into minutes with min_p.
  - Minutes carry the same way into hour with hour_p.
  - Hour 23 wraps to 0 with day_p.
  - sec_p is asserted on every tick.
  - Pulses are registered: high for exactly the cycle after the tick edge.
- Set mode (set_clk = 1):
  - Prescaler held at 0; no ticks and no pulses.
  - set_* inputs are synchronous to clk. A rising edge means current = 1 and previous sample = 0.
  - Simultaneous edges on several set_* inputs all apply in the same cycle; field increments never carry.
  - set_* edges are ignored when set_clk = 0. Edge history is tracked in both modes.
- Leaving set mode: first tick occurs TICK_DIV cycles after the cycle set_clk is sampled 0.
- Display hour:
  - mode_12h = 0: BCD of hour.
  - mode_12h = 1: hour 0 -> 12; 1-12 -> same; 13-23 -> hour-12.
  - mode_12h affects display only; it may change at any time with no state change.
- Alarm:
  - alarm_flag sets on the edge where a run tick makes the time alarm_hour:alarm_min:00 and alarm_en = 1.
  - Set-mode changes never fire the alarm.
  - alarm_ack clears the flag. If ack and a new match occur in the same cycle, set wins.
  - Out-of-range alarm values simply never match.
- Reset mid-operation: immediate asynchronous return to reset values, including during set mode.

Test Plan:
- TICK_DIV=4, release reset, run 4*60 cycles -> time 00:01:00; one min_p; 60 sec_p; min_p coincides with sec_hi=0 display.
- Set time to 23:59:58 via set mode, exit, run 8 cycles -> 00:00:00; day_p, hour_p and min_p asserted in the same cycle; pm 1->0.
- mode_12h=1 at hours 0, 11, 12, 13, 23 -> display 12, 11, 12, 01, 11 with pm 0, 0, 1, 1, 1.
- Set mode at 10:59:xx, pulse set_min once, then set_sec -> 10:00:00 (no hour carry). Pulse set_hour 15 times -> 01:00:00. No pulses emitted; holding set_min high counts once.
- alarm 07:30, en=1, run from 07:29:58 -> alarm_flag rises with the 07:30:00 display. alarm_ack clears it. alarm_en=0 repeat -> no flag.
- Assert rst mid-count at 05:12:34 (and again in set mode) -> all outputs immediately reset; hour = INIT_HOUR.
